// File: rtl/regbank_pkg.sv
// Shared definitions for the register bank: function-select encoding and select-width helper.
package regbank_pkg;

  localparam logic [1:0] FS_DEC  = 2'b00;
  localparam logic [1:0] FS_INC  = 2'b01;
  localparam logic [1:0] FS_LOAD = 2'b10;
  localparam logic [1:0] FS_CLR  = 2'b11;

  // A bank of one register still needs a 1-bit select port.
  function automatic int sel_w(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/register_cell.sv
// One N-bit register of the bank: dec/inc/load/clear with wrap or saturate at the boundaries.
module register_cell
  import regbank_pkg::*;
#(
  parameter int         N         = 8,
  parameter bit         SATURATE  = 1'b0,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [1:0]   funsel,
  input  logic [N-1:0] load,
  output logic [N-1:0] q,
  output logic         zero,
  output logic         bound_hit
);

  logic [N-1:0] r_q;
  logic [N-1:0] w_next;
  logic         w_hit;

  always_comb begin
    w_next = r_q;
    w_hit  = 1'b0;
    if (en) begin
      case (funsel)
        FS_DEC: begin
          if (r_q == '0) begin
            w_hit  = 1'b1;
            w_next = SATURATE ? '0 : '1;
          end else begin
            w_next = r_q - 1'b1;
          end
        end
        FS_INC: begin
          if (r_q == '1) begin
            w_hit  = 1'b1;
            w_next = SATURATE ? '1 : '0;
          end else begin
            w_next = r_q + 1'b1;
          end
        end
        FS_LOAD: w_next = load;
        FS_CLR:  w_next = RESET_VAL;
        default: w_next = r_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= RESET_VAL;
    else        r_q <= w_next;
  end

  assign q         = r_q;
  assign zero      = (r_q == '0);
  assign bound_hit = w_hit;

endmodule

// File: rtl/register_bank.sv
// R x N general-purpose register array with shared function select, two combinational read ports
// and a registered wrap/saturate event pulse.
module register_bank
  import regbank_pkg::*;
#(
  parameter int           N         = 8,
  parameter int           R         = 4,
  parameter bit           SATURATE  = 1'b0,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [R-1:0]        reg_en,
  input  logic [1:0]          funsel,
  input  logic [N-1:0]        load,
  input  logic [sel_w(R)-1:0] sel_a,
  input  logic [sel_w(R)-1:0] sel_b,
  output logic [N-1:0]        out_a,
  output logic [N-1:0]        out_b,
  output logic [R-1:0]        zero_flags,
  output logic                wrap_evt
);

  localparam int SEL_W = sel_w(R);

  logic [N-1:0] w_q [R];
  logic [R-1:0] w_hit;
  logic         r_wrap;

  for (genvar i = 0; i < R; i++) begin : g_cell
    register_cell #(
      .N         (N),
      .SATURATE  (SATURATE),
      .RESET_VAL (RESET_VAL)
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (reg_en[i]),
      .funsel    (funsel),
      .load      (load),
      .q         (w_q[i]),
      .zero      (zero_flags[i]),
      .bound_hit (w_hit[i])
    );
  end

  // Out-of-range selects fall through to zero because no index matches.
  always_comb begin
    out_a = '0;
    out_b = '0;
    for (int i = 0; i < R; i++) begin
      if (sel_a == SEL_W'(i)) out_a = w_q[i];
      if (sel_b == SEL_W'(i)) out_b = w_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wrap <= 1'b0;
    else        r_wrap <= |w_hit;
  end

  assign wrap_evt = r_wrap;

endmodule

// File: tb/tb_register_bank.sv
// Directed self-checking bench for register_bank (wrap build plus a saturating build).
module tb_register_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] reg_en = '0;
  logic [3:0] reg_en_s = '0;
  logic [1:0] funsel = 2'b00;
  logic [7:0] load = '0;
  logic [1:0] sel_a = '0;
  logic [1:0] sel_b = '0;
  logic [7:0] out_a, out_b, out_a_s, out_b_s;
  logic [3:0] zero_flags, zf_s;
  logic       wrap_evt, wrap_s;

  int n_vec = 0;
  int n_err = 0;

  always #10 clk = ~clk;

  register_bank #(.N(8), .R(4), .SATURATE(1'b0), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .reg_en(reg_en), .funsel(funsel), .load(load),
    .sel_a(sel_a), .sel_b(sel_b), .out_a(out_a), .out_b(out_b),
    .zero_flags(zero_flags), .wrap_evt(wrap_evt)
  );

  register_bank #(.N(8), .R(4), .SATURATE(1'b1), .RESET_VAL(8'h00)) dut_sat (
    .clk(clk), .rst_n(rst_n), .reg_en(reg_en_s), .funsel(funsel), .load(load),
    .sel_a(sel_a), .sel_b(sel_b), .out_a(out_a_s), .out_b(out_b_s),
    .zero_flags(zf_s), .wrap_evt(wrap_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int i, output logic [7:0] va, output logic [7:0] vb);
    sel_a = 2'(i);
    sel_b = 2'(i);
    #1;
    va = out_a;
    vb = out_b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reg_en = '0;
    reg_en_s = '0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    reg_en = 4'b1111;
    funsel = 2'b10;
    load = 8'hA5;
    sel_a = 2'd0;
    sel_b = 2'd3;
    step();
    n_vec++;
    if (out_a !== 8'hA5) begin n_err++; $display("FAIL reset_preload got %h exp a5", out_a); end
    #2;
    reg_en = '0;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_a !== 8'h00 || out_b !== 8'h00) begin
      n_err++; $display("FAIL reset_async_out got a=%h b=%h exp 00/00", out_a, out_b);
    end
    n_vec++;
    if (zero_flags !== 4'b1111) begin n_err++; $display("FAIL reset_zero_flags got %b exp 1111", zero_flags); end
    n_vec++;
    if (wrap_evt !== 1'b0) begin n_err++; $display("FAIL reset_wrap got %b exp 0", wrap_evt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_read();
    @(negedge clk);
    reg_en = 4'b0101;
    funsel = 2'b10;
    load = 8'hA5;
    sel_a = 2'd0;
    sel_b = 2'd1;
    #1;
    n_vec++;
    if (out_a !== 8'h00) begin n_err++; $display("FAIL no_bypass got %h exp 00", out_a); end
    step();
    n_vec++;
    if (out_a !== 8'hA5 || out_b !== 8'h00) begin
      n_err++; $display("FAIL load_read got a=%h b=%h exp a5/00", out_a, out_b);
    end
    n_vec++;
    if (zero_flags !== 4'b1010) begin n_err++; $display("FAIL load_zero_flags got %b exp 1010", zero_flags); end
    sel_a = 2'd2;
    sel_b = 2'd2;
    #1;
    n_vec++;
    if (out_a !== 8'hA5 || out_b !== 8'hA5) begin
      n_err++; $display("FAIL same_sel got a=%h b=%h exp a5/a5", out_a, out_b);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    reg_en = 4'b0100;
    funsel = 2'b10;
    load = 8'hFF;
    sel_a = 2'd2;
    step();
    n_vec++;
    if (out_a !== 8'hFF || wrap_evt !== 1'b0) begin
      n_err++; $display("FAIL wrap_load got %h/%b exp ff/0", out_a, wrap_evt);
    end
    @(negedge clk);
    funsel = 2'b01;
    step();
    n_vec++;
    if (out_a !== 8'h00 || zero_flags !== 4'b1110 || wrap_evt !== 1'b1) begin
      n_err++; $display("FAIL wrap_inc got %h/%b/%b exp 00/1110/1", out_a, zero_flags, wrap_evt);
    end
    @(negedge clk);
    reg_en = 4'b0000;
    step();
    n_vec++;
    if (wrap_evt !== 1'b0 || out_a !== 8'h00) begin
      n_err++; $display("FAIL wrap_inc_pulse_end got %h/%b exp 00/0", out_a, wrap_evt);
    end
    @(negedge clk);
    reg_en = 4'b0100;
    funsel = 2'b00;
    step();
    n_vec++;
    if (out_a !== 8'hFF || wrap_evt !== 1'b1) begin
      n_err++; $display("FAIL wrap_dec got %h/%b exp ff/1", out_a, wrap_evt);
    end
    @(negedge clk);
    reg_en = 4'b0000;
    step();
    n_vec++;
    if (wrap_evt !== 1'b0) begin n_err++; $display("FAIL wrap_dec_pulse_end got %b exp 0", wrap_evt); end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    reg_en = '0;
    reg_en_s = 4'b1000;
    funsel = 2'b00;
    sel_a = 2'd3;
    for (int k = 0; k < 2; k++) begin
      step();
      n_vec++;
      if (out_a_s !== 8'h00 || wrap_s !== 1'b1) begin
        n_err++; $display("FAIL sat_dec%0d got %h/%b exp 00/1", k, out_a_s, wrap_s);
      end
    end
    @(negedge clk);
    funsel = 2'b10;
    load = 8'hFE;
    step();
    @(negedge clk);
    funsel = 2'b01;
    step();
    n_vec++;
    if (out_a_s !== 8'hFF || wrap_s !== 1'b0) begin
      n_err++; $display("FAIL sat_inc_fe got %h/%b exp ff/0", out_a_s, wrap_s);
    end
    step();
    n_vec++;
    if (out_a_s !== 8'hFF || wrap_s !== 1'b1) begin
      n_err++; $display("FAIL sat_inc_ff got %h/%b exp ff/1", out_a_s, wrap_s);
    end
    @(negedge clk);
    reg_en_s = '0;
  endtask

  task automatic test_enable_sweep();
    logic [7:0] exp_v [4];
    logic       exp_w [4];
    logic [7:0] va, vb;
    exp_v[0] = 8'hF4; exp_w[0] = 1'b0;
    exp_v[1] = 8'h00; exp_w[1] = 1'b1;
    exp_v[2] = 8'h01; exp_w[2] = 1'b0;
    exp_v[3] = 8'h00; exp_w[3] = 1'b0;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      for (int f = 0; f < 4; f++) begin
        @(negedge clk);
        reg_en = (pass == 0) ? 4'b1111 : 4'b0000;
        funsel = 2'(f);
        load = 8'h01;
        repeat (12) step();
        n_vec++;
        if (wrap_evt !== ((pass == 0) ? exp_w[f] : 1'b0)) begin
          n_err++; $display("FAIL sweep_wrap p%0d f%0d got %b", pass, f, wrap_evt);
        end
        for (int i = 0; i < 4; i++) begin
          rd(i, va, vb);
          n_vec++;
          if (va !== ((pass == 0) ? exp_v[f] : 8'h00) || vb !== va) begin
            n_err++; $display("FAIL sweep p%0d f%0d r%0d got a=%h b=%h exp %h", pass, f, i, va, vb,
                              (pass == 0) ? exp_v[f] : 8'h00);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] va, vb;
    @(negedge clk);
    reg_en = 4'b1110;
    funsel = 2'b10;
    load = 8'hFF;
    step();
    @(negedge clk);
    reg_en = 4'b1111;
    funsel = 2'b01;
    sel_a = 2'd0;
    sel_b = 2'd1;
    step();
    n_vec++;
    if (out_a !== 8'h01 || out_b !== 8'h00 || wrap_evt !== 1'b1) begin
      n_err++; $display("FAIL mid_pre got %h/%h/%b exp 01/00/1", out_a, out_b, wrap_evt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_a !== 8'h00 || zero_flags !== 4'b1111 || wrap_evt !== 1'b0) begin
      n_err++; $display("FAIL mid_reset got %h/%b/%b exp 00/1111/0", out_a, zero_flags, wrap_evt);
    end
    #2;
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      rd(i, va, vb);
      n_vec++;
      if (va !== 8'h01) begin n_err++; $display("FAIL mid_release r%0d got %h exp 01", i, va); end
    end
    n_vec++;
    if (zero_flags !== 4'b0000) begin n_err++; $display("FAIL mid_release_zf got %b exp 0000", zero_flags); end
  endtask

  initial begin
    #25;
    test_reset();
    test_load_read();
    test_wrap();
    test_saturate();
    test_enable_sweep();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
